// File: rtl/reg_writeback_ctrl_if.sv
// Writeback handshake, load-return and register-file write bundle.
interface reg_writeback_ctrl_if;
   logic        in_valid;
   logic        in_ready;
   logic        in_rf_wen;
   logic [4:0]  in_rd_addr;
   logic [1:0]  in_wb_sel;
   logic [31:0] in_alu_out;
   logic [31:0] in_pc;
   logic [2:0]  in_funct3;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        write_en;
   logic [4:0]  write_addr;
   logic [31:0] write_value;
   logic        err;
   logic        fwd_valid;
   logic [4:0]  fwd_addr;
   logic [31:0] fwd_data;

   modport master (
      output in_valid, in_rf_wen, in_rd_addr, in_wb_sel,
      output in_alu_out, in_pc, in_funct3, mem_rvalid, mem_rdata,
      input  in_ready, write_en, write_addr, write_value, err,
      input  fwd_valid, fwd_addr, fwd_data
   );

   modport slave (
      input  in_valid, in_rf_wen, in_rd_addr, in_wb_sel,
      input  in_alu_out, in_pc, in_funct3, mem_rvalid, mem_rdata,
      output in_ready, write_en, write_addr, write_value, err,
      output fwd_valid, fwd_addr, fwd_data
   );
endinterface

// File: rtl/reg_writeback_ctrl.sv
// Writeback controller: ALU/PC+4/load results to register file.
// Define WB_FWD_EN to enable the forwarding port.
module reg_writeback_ctrl #(
   parameter int MEM_TIMEOUT = 255
) (
   input logic              clk,
   input logic              reset,
   reg_writeback_ctrl_if.slave bus
);
   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] WAIT_MEM = 2'd1;
   localparam logic [1:0] WRITE    = 2'd2;

   localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT =
      (MEM_TIMEOUT < 1) ? '0 : CW'(MEM_TIMEOUT - 1);

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [4:0]    rd_q, rd_d;
   logic          wen_q, wen_d;
   logic [2:0]    f3_q, f3_d;
   logic [1:0]    off_q, off_d;
   logic [31:0]   val_q, val_d;
   logic          err_q, err_d;

   logic        rdy;
   logic        accept;
   logic        in_wr;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_val;
   logic        ld_bad;

   assign rdy    = !reset && (state_q != WAIT_MEM);
   assign accept = bus.in_valid && rdy;
   assign in_wr  = !reset && (state_q == WRITE);

   always_comb begin
      ld_byte = 8'h00;
      unique case (off_q)
         2'd0: ld_byte = bus.mem_rdata[7:0];
         2'd1: ld_byte = bus.mem_rdata[15:8];
         2'd2: ld_byte = bus.mem_rdata[23:16];
         2'd3: ld_byte = bus.mem_rdata[31:24];
         default: ld_byte = 8'h00;
      endcase
      ld_half = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
      ld_val  = 32'h0;
      ld_bad  = 1'b0;
      unique case (f3_q)
         3'b000: ld_val = {{24{ld_byte[7]}}, ld_byte};
         3'b001: ld_val = {{16{ld_half[15]}}, ld_half};
         3'b010: ld_val = bus.mem_rdata;
         3'b100: ld_val = {24'h0, ld_byte};
         3'b101: ld_val = {16'h0, ld_half};
         default: ld_bad = 1'b1;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rd_d    = rd_q;
      wen_d   = wen_q;
      f3_d    = f3_q;
      off_d   = off_q;
      val_d   = val_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE, WRITE: begin
            state_d = IDLE;
            if (accept) begin
               rd_d  = bus.in_rd_addr;
               wen_d = bus.in_rf_wen && (bus.in_rd_addr != 5'd0)
                       && (bus.in_wb_sel != 2'd3);
               f3_d  = bus.in_funct3;
               off_d = bus.in_alu_out[1:0];
               if (bus.in_wb_sel == 2'd1) begin
                  state_d = WAIT_MEM;
                  cnt_d   = '0;
               end else begin
                  state_d = WRITE;
                  val_d   = (bus.in_wb_sel == 2'd2) ?
                            bus.in_pc + 32'd4 : bus.in_alu_out;
               end
            end
         end
         WAIT_MEM: begin
            // rvalid takes priority over a coincident timeout
            if (bus.mem_rvalid) begin
               val_d   = ld_val;
               err_d   = err_q | ld_bad;
               state_d = WRITE;
            end else if (cnt_q == LIMIT) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rd_q    <= 5'd0;
         wen_q   <= 1'b0;
         f3_q    <= 3'd0;
         off_q   <= 2'd0;
         val_q   <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         wen_q   <= wen_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
         val_q   <= val_d;
         err_q   <= err_d;
      end
   end

   assign bus.in_ready    = rdy;
   assign bus.write_en    = in_wr && wen_q;
   assign bus.write_addr  = in_wr ? rd_q : 5'd0;
   assign bus.write_value = in_wr ? val_q : 32'h0;
   assign bus.err         = !reset && err_q;

`ifdef WB_FWD_EN
   logic fwd_mem;
   assign fwd_mem = !reset && (state_q == WAIT_MEM)
                    && bus.mem_rvalid && wen_q;
   assign bus.fwd_valid = bus.write_en || fwd_mem;
   assign bus.fwd_addr  = bus.fwd_valid ? rd_q : 5'd0;
   assign bus.fwd_data  = fwd_mem ? ld_val :
                          (bus.write_en ? val_q : 32'h0);
`else
   assign bus.fwd_valid = 1'b0;
   assign bus.fwd_addr  = 5'd0;
   assign bus.fwd_data  = 32'h0;
`endif
endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Directed bench for reg_writeback_ctrl (MEM_TIMEOUT=8).
module tb_reg_writeback_ctrl;
   logic clk;
   logic reset;
   int   tests;
   int   fails;

   reg_writeback_ctrl_if bus ();

   reg_writeback_ctrl #(.MEM_TIMEOUT(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] sel,
                        input logic [4:0] rd, input logic [31:0] alu,
                        input logic [31:0] pc, input logic [2:0] f3);
      bus.in_valid   = v;
      bus.in_rf_wen  = 1'b1;
      bus.in_wb_sel  = sel;
      bus.in_rd_addr = rd;
      bus.in_alu_out = alu;
      bus.in_pc      = pc;
      bus.in_funct3  = f3;
   endtask

   task automatic load_chk(input string tag, input logic [2:0] f3,
                           input logic [1:0] off, input logic [4:0] rd,
                           input logic [31:0] rdata,
                           input logic [31:0] exp);
      drive(1'b1, 2'd1, rd, {30'h0, off}, 32'h0, f3);
      step();
      bus.in_valid = 1'b0;
      chk({tag, "_rdy_wait"}, {31'h0, bus.in_ready}, 32'd0);
      step();
      step();
      step();
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = rdata;
      step();
      bus.mem_rvalid = 1'b0;
      chk({tag, "_wen"}, {31'h0, bus.write_en}, 32'd1);
      chk({tag, "_addr"}, {27'h0, bus.write_addr}, {27'h0, rd});
      chk({tag, "_val"}, bus.write_value, exp);
      step();
      chk({tag, "_wen_off"}, {31'h0, bus.write_en}, 32'd0);
   endtask

   task automatic outs_zero(input string tag);
      chk({tag, "_rdy"}, {31'h0, bus.in_ready}, 32'd0);
      chk({tag, "_wen"}, {31'h0, bus.write_en}, 32'd0);
      chk({tag, "_addr"}, {27'h0, bus.write_addr}, 32'd0);
      chk({tag, "_val"}, bus.write_value, 32'd0);
      chk({tag, "_err"}, {31'h0, bus.err}, 32'd0);
      chk({tag, "_fv"}, {31'h0, bus.fwd_valid}, 32'd0);
      chk({tag, "_fa"}, {27'h0, bus.fwd_addr}, 32'd0);
      chk({tag, "_fd"}, bus.fwd_data, 32'd0);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      reset = 1'b1;
      drive(1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 3'd0);
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 32'h0;
      step();
      step();
      outs_zero("reset");

      reset = 1'b0;
      step();
      chk("idle_rdy", {31'h0, bus.in_ready}, 32'd1);

      // ALU result
      drive(1'b1, 2'd0, 5'd5, 32'h1234, 32'h0, 3'd0);
      step();
      bus.in_valid = 1'b0;
      chk("alu_wen", {31'h0, bus.write_en}, 32'd1);
      chk("alu_addr", {27'h0, bus.write_addr}, 32'd5);
      chk("alu_val", bus.write_value, 32'h1234);
      chk("alu_fwd_off", {31'h0, bus.fwd_valid}, 32'd0);
      step();
      chk("alu_wen_off", {31'h0, bus.write_en}, 32'd0);

      // loads
      load_chk("lb3", 3'b000, 2'd3, 5'd7, 32'h80FF_FF00, 32'hFFFF_FF80);
      load_chk("lhu2", 3'b101, 2'd2, 5'd8, 32'h80FF_FF00, 32'h0000_80FF);
      load_chk("lh0", 3'b001, 2'd0, 5'd9, 32'h80FF_FF00, 32'hFFFF_FF00);
      load_chk("lbu1", 3'b100, 2'd1, 5'd10, 32'h1234_8A00, 32'h0000_008A);
      load_chk("lw", 3'b010, 2'd0, 5'd11, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      chk("loads_err", {31'h0, bus.err}, 32'd0);

      // PC+4 wrap, rd=1 then rd=0
      drive(1'b1, 2'd2, 5'd1, 32'h0, 32'hFFFF_FFFC, 3'd0);
      step();
      bus.in_valid = 1'b0;
      chk("pc4_wen", {31'h0, bus.write_en}, 32'd1);
      chk("pc4_val", bus.write_value, 32'h0);
      step();
      drive(1'b1, 2'd2, 5'd0, 32'h0, 32'hFFFF_FFFC, 3'd0);
      step();
      bus.in_valid = 1'b0;
      chk("pc4_rd0_wen", {31'h0, bus.write_en}, 32'd0);
      step();
      chk("pc4_rd0_wen2", {31'h0, bus.write_en}, 32'd0);

      // wb_sel none and rf_wen=0
      drive(1'b1, 2'd3, 5'd4, 32'h55, 32'h0, 3'd0);
      step();
      chk("none_wen", {31'h0, bus.write_en}, 32'd0);
      drive(1'b1, 2'd0, 5'd4, 32'h66, 32'h0, 3'd0);
      bus.in_rf_wen = 1'b0;
      step();
      bus.in_valid = 1'b0;
      chk("nowen_wen", {31'h0, bus.write_en}, 32'd0);
      step();

      // back-to-back ALU results
      drive(1'b1, 2'd0, 5'd1, 32'hA1, 32'h0, 3'd0);
      step();
      drive(1'b1, 2'd0, 5'd2, 32'hB2, 32'h0, 3'd0);
      chk("b2b1_wen", {31'h0, bus.write_en}, 32'd1);
      chk("b2b1_val", bus.write_value, 32'hA1);
      step();
      drive(1'b1, 2'd0, 5'd3, 32'hC3, 32'h0, 3'd0);
      chk("b2b2_wen", {31'h0, bus.write_en}, 32'd1);
      chk("b2b2_addr", {27'h0, bus.write_addr}, 32'd2);
      chk("b2b2_val", bus.write_value, 32'hB2);
      step();
      bus.in_valid = 1'b0;
      chk("b2b3_wen", {31'h0, bus.write_en}, 32'd1);
      chk("b2b3_val", bus.write_value, 32'hC3);
      step();
      chk("b2b_end", {31'h0, bus.write_en}, 32'd0);

      // stray rvalid in IDLE
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h1111_1111;
      step();
      bus.mem_rvalid = 1'b0;
      chk("stray_wen", {31'h0, bus.write_en}, 32'd0);
      chk("stray_rdy", {31'h0, bus.in_ready}, 32'd1);

      // rvalid on the 8th WAIT_MEM cycle wins
      drive(1'b1, 2'd1, 5'd12, 32'h0, 32'h0, 3'b010);
      step();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 7; i++) step();
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hCAFE_F00D;
      step();
      bus.mem_rvalid = 1'b0;
      chk("late_wen", {31'h0, bus.write_en}, 32'd1);
      chk("late_val", bus.write_value, 32'hCAFE_F00D);
      chk("late_err", {31'h0, bus.err}, 32'd0);
      step();

      // timeout after 8 WAIT_MEM cycles
      drive(1'b1, 2'd1, 5'd13, 32'h0, 32'h0, 3'b010);
      step();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 7; i++) step();
      chk("to_pre_err", {31'h0, bus.err}, 32'd0);
      chk("to_pre_rdy", {31'h0, bus.in_ready}, 32'd0);
      step();
      chk("to_err", {31'h0, bus.err}, 32'd1);
      chk("to_wen", {31'h0, bus.write_en}, 32'd0);
      chk("to_rdy", {31'h0, bus.in_ready}, 32'd1);
      step();
      step();
      chk("to_sticky", {31'h0, bus.err}, 32'd1);

      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      chk("rst_clr_err", {31'h0, bus.err}, 32'd0);

      // undefined funct3 load writes 0 and flags err
      load_chk("bad_f3", 3'b011, 2'd0, 5'd14, 32'hFFFF_FFFF, 32'h0);
      chk("bad_f3_err", {31'h0, bus.err}, 32'd1);

      // reset while waiting on memory drops the write
      drive(1'b1, 2'd1, 5'd15, 32'h0, 32'h0, 3'b010);
      step();
      bus.in_valid   = 1'b0;
      reset          = 1'b1;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h7777_7777;
      #1;
      outs_zero("rst_wait_comb");
      step();
      outs_zero("rst_wait");
      reset          = 1'b0;
      bus.mem_rvalid = 1'b0;
      step();
      chk("rst_wait_wen", {31'h0, bus.write_en}, 32'd0);
      chk("rst_wait_rdy", {31'h0, bus.in_ready}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/reg_writeback_ctrl.md
REG_WRITEBACK_CTRL -- requirements
Module: reg_writeback_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 255, meaning the maximum number of cycles spent in WAIT_MEM before abandoning a load.
REQ-002 clk  in  1  clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 in_valid  in  1  an execute-stage result is presented.
REQ-005 in_ready  out  1  the block accepts the presented result this cycle.
REQ-006 in_rf_wen  in  1  the instruction writes a destination register.
REQ-007 in_rd_addr  in  5  destination register index.
REQ-008 in_wb_sel  in  2  result source: 0 ALU, 1 MEM, 2 PC+4, 3 none.
REQ-009 in_alu_out  in  32  ALU result; bits [1:0] are the load byte offset when in_wb_sel=1.
REQ-010 in_pc  in  32  instruction PC.
REQ-011 in_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-012 mem_rvalid  in  1  load data valid.
REQ-013 mem_rdata  in  32  raw load word.
REQ-014 write_en, write_addr, write_value  out  1/5/32  register-file write port.
REQ-015 err  out  1  sticky error flag.
REQ-016 fwd_valid, fwd_addr, fwd_data  out  1/5/32  forwarding port (see Configuration).

Function
REQ-017 The FSM SHALL have states IDLE, WAIT_MEM and WRITE.
REQ-018 in_ready SHALL be 1 in IDLE and WRITE, and 0 in WAIT_MEM and while reset is high.
REQ-019 Handshake: a result SHALL be accepted only on a cycle where in_valid=1 and in_ready=1; all inputs are captured in that cycle.
REQ-020 Accept with in_wb_sel 0, 2 or 3 SHALL go to WRITE; write data is ALU = in_alu_out, PC+4 = in_pc+4 modulo 2^32 (0xFFFFFFFC wraps to 0), none = no write.
REQ-021 Accept with in_wb_sel=1 SHALL go to WAIT_MEM and clear the timeout counter.
REQ-022 In WAIT_MEM with mem_rvalid=1 the block SHALL extract and extend the load data and go to WRITE.
REQ-023 Extraction: LB/LBU take byte offset[1:0]; LH/LHU take halfword offset[1]; LW takes the whole word. B/H are sign-extended, BU/HU zero-extended.
REQ-024 A load with an undefined in_funct3 SHALL write 0 and set err.
REQ-025 In WRITE, write_en SHALL be 1 for exactly one cycle, with write_addr and write_value held stable for that cycle; result latency is 1 cycle after accept (non-MEM) or 1 cycle after mem_rvalid (MEM).
REQ-026 write_en SHALL remain 0 in WRITE when in_rf_wen=0, in_rd_addr=0 or in_wb_sel=3; the FSM still passes through WRITE.
REQ-027 An accept in WRITE SHALL chain directly to WRITE or WAIT_MEM, sustaining one result per cycle for non-MEM results; otherwise WRITE SHALL return to IDLE.
REQ-028 mem_rvalid outside WAIT_MEM SHALL be ignored.
REQ-029 In WAIT_MEM the counter SHALL increment each cycle; when it reaches MEM_TIMEOUT without mem_rvalid, the block SHALL set err, perform no write and go to IDLE.
REQ-030 If mem_rvalid is asserted in the same cycle as the timeout, mem_rvalid SHALL win and no error is raised.
REQ-031 err SHALL stay at 1 until reset.

Reset
REQ-032 Reset SHALL put the FSM in IDLE and clear the timeout counter.
REQ-033 During reset, write_en, write_addr, write_value, err, fwd_valid, fwd_addr and fwd_data SHALL all be 0, and in_ready SHALL be 0.
REQ-034 Reset asserted in WAIT_MEM or WRITE SHALL drop the pending write with no write_en pulse.

Configuration
REQ-035 With WB_FWD_EN defined, fwd_valid, fwd_addr and fwd_data SHALL present combinationally the write that the next WRITE cycle will perform: non-MEM results from the cycle after accept, loads in the mem_rvalid cycle.
REQ-036 Without WB_FWD_EN, fwd_valid, fwd_addr and fwd_data SHALL be constant 0 and carry no logic.

Verification
REQ-037 ALU accept, rd=5, alu=0x1234 -> next cycle write_en=1, addr=5, value=0x1234; the cycle after, write_en=0.
REQ-038 LB, offset 3, mem_rdata=0x80FF_FF00 after 4 cycles -> write_value=0xFFFFFF80; LHU, offset 2 -> 0x000080FF.
REQ-039 PC+4 with pc=0xFFFFFFFC, rd=1 -> write_value=0; same with rd=0 -> write_en never 1.
REQ-040 Load with MEM_TIMEOUT=8 and no mem_rvalid -> err=1 after 8 WAIT_MEM cycles, no write, in_ready returns to 1; rvalid on cycle 8 -> write, err=0.
REQ-041 Back-to-back ALU results on 3 consecutive cycles -> 3 consecutive write_en pulses; reset asserted in WAIT_MEM -> no write and all outputs 0.
